// File: rtl/io_pad_in_conditioner_if.sv
// Bundle between a GPIO input channel and its conditioner: raw pin,
// configuration and controls in, conditioned level, pulses, count and interrupt out.
interface io_pad_in_conditioner_if #(
    parameter int DEBOUNCE_W = 8,
    parameter int EDGE_CNT_W = 16
);
    logic                  rdata_i;
    logic [DEBOUNCE_W-1:0] debounce_cycles_i;
    logic [1:0]            irq_en_i;
    logic                  irq_clr_i;
    logic                  cnt_clr_i;
    logic                  sync_o;
    logic                  level_o;
    logic                  rise_o;
    logic                  fall_o;
    logic [EDGE_CNT_W-1:0] edge_cnt_o;
    logic                  irq_o;

    modport master (
        output rdata_i,
        output debounce_cycles_i,
        output irq_en_i,
        output irq_clr_i,
        output cnt_clr_i,
        input  sync_o,
        input  level_o,
        input  rise_o,
        input  fall_o,
        input  edge_cnt_o,
        input  irq_o
    );

    modport slave (
        input  rdata_i,
        input  debounce_cycles_i,
        input  irq_en_i,
        input  irq_clr_i,
        input  cnt_clr_i,
        output sync_o,
        output level_o,
        output rise_o,
        output fall_o,
        output edge_cnt_o,
        output irq_o
    );
endinterface

// File: rtl/io_pad_in_conditioner.sv
// GPIO input conditioner: synchroniser, programmable debounce, edge
// pulses, wrapping edge counter and sticky maskable interrupt.
module io_pad_in_conditioner #(
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE_W  = 8,
    parameter int EDGE_CNT_W  = 16,
    parameter bit RESET_VALUE = 1'b0
) (
    input logic clk_i,
    input logic rst_i,
    io_pad_in_conditioner_if.slave bus
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;
    logic                   level_q;
    logic [DEBOUNCE_W-1:0]  stab_q;
    logic                   rise_q;
    logic                   fall_q;
    logic [EDGE_CNT_W-1:0]  ecnt_q;
    logic                   irq_q;

    logic mismatch;
    logic commit;
    logic rise_d;
    logic fall_d;
    logic irq_set;

    assign sync = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= {SYNC_STAGES{RESET_VALUE}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.rdata_i};
        end
    end

    // A new value is accepted once it has mismatched for N+1 edges.
    assign mismatch = (sync != level_q);
    assign commit   = mismatch && (stab_q >= bus.debounce_cycles_i);
    assign rise_d   = commit && sync;
    assign fall_d   = commit && !sync;
    assign irq_set  = (rise_d && bus.irq_en_i[0]) ||
                      (fall_d && bus.irq_en_i[1]);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            level_q <= RESET_VALUE;
            stab_q  <= '0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            ecnt_q  <= '0;
            irq_q   <= 1'b0;
        end else begin
            rise_q <= rise_d;
            fall_q <= fall_d;

            if (!mismatch) begin
                stab_q <= '0;
            end else if (commit) begin
                level_q <= sync;
                stab_q  <= '0;
            end else begin
                stab_q <= stab_q + DEBOUNCE_W'(1);
            end

            if (bus.cnt_clr_i) begin
                ecnt_q <= commit ? EDGE_CNT_W'(1) : '0;
            end else if (commit) begin
                ecnt_q <= ecnt_q + EDGE_CNT_W'(1);
            end

            // Set wins over a coincident clear.
            if (irq_set) begin
                irq_q <= 1'b1;
            end else if (bus.irq_clr_i) begin
                irq_q <= 1'b0;
            end
        end
    end

    assign bus.sync_o     = sync;
    assign bus.level_o    = level_q;
    assign bus.rise_o     = rise_q;
    assign bus.fall_o     = fall_q;
    assign bus.edge_cnt_o = ecnt_q;
    assign bus.irq_o      = irq_q;

endmodule

// File: tb/tb_io_pad_in_conditioner.sv
// Directed bench for io_pad_in_conditioner; edge counter narrowed to
// 4 bits so the wrap is reachable.
module tb_io_pad_in_conditioner;

    localparam int DW = 8;
    localparam int CW = 4;

    logic clk_i = 1'b0;
    logic rst_i;
    int   n_vec = 0;
    int   n_err = 0;
    int   n_rise;
    int   n_fall;
    int   n_both;
    logic [3:0] hist;

    io_pad_in_conditioner_if #(.DEBOUNCE_W(DW), .EDGE_CNT_W(CW)) bus ();

    io_pad_in_conditioner #(
        .SYNC_STAGES(2),
        .DEBOUNCE_W (DW),
        .EDGE_CNT_W (CW),
        .RESET_VALUE(1'b0)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .bus  (bus)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One edge; bench model keeps what rdata_i was sampled at each edge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_i);
            hist = {hist[2:0], bus.rdata_i};
            #1;
            if (bus.rise_o) n_rise++;
            if (bus.fall_o) n_fall++;
            if (bus.rise_o && bus.fall_o) n_both++;
        end
    endtask

    initial begin
        hist                  = '0;
        rst_i                 = 1'b1;
        bus.rdata_i           = 1'b1;
        bus.debounce_cycles_i = 8'd3;
        bus.irq_en_i          = 2'b00;
        bus.irq_clr_i         = 1'b0;
        bus.cnt_clr_i         = 1'b0;

        // 1: reset and first accepted rise
        step(3);
        chk("rst_sync",  bus.sync_o, 0);
        chk("rst_level", bus.level_o, 0);
        chk("rst_rise",  bus.rise_o, 0);
        chk("rst_fall",  bus.fall_o, 0);
        chk("rst_cnt",   bus.edge_cnt_o, 0);
        chk("rst_irq",   bus.irq_o, 0);
        rst_i = 1'b0;
        step(1);
        chk("sync_e1", bus.sync_o, 0);
        step(1);
        chk("sync_e2", bus.sync_o, 1);
        step(3);
        chk("lvl_e5", bus.level_o, 0);
        step(1);
        chk("lvl_e6",  bus.level_o, 1);
        chk("rise_e6", bus.rise_o, 1);
        chk("cnt_e6",  bus.edge_cnt_o, 1);
        step(1);
        chk("rise_e7", bus.rise_o, 0);

        // 2: glitch rejection, then accepted pulse
        bus.rdata_i = 1'b0;
        step(10);
        chk("t2_lvl0", bus.level_o, 0);
        chk("t2_cnt0", bus.edge_cnt_o, 2);
        n_rise = 0;
        bus.rdata_i = 1'b1;
        step(3);
        bus.rdata_i = 1'b0;
        step(10);
        chk("glitch_lvl",  bus.level_o, 0);
        chk("glitch_rise", n_rise, 0);
        chk("glitch_cnt",  bus.edge_cnt_o, 2);
        bus.rdata_i = 1'b1;
        step(4);
        bus.rdata_i = 1'b0;
        step(1);
        chk("pulse_e5", bus.level_o, 0);
        step(1);
        chk("pulse_e6",  bus.level_o, 1);
        chk("pulse_r6",  bus.rise_o, 1);
        step(3);
        chk("pulse_e9", bus.level_o, 1);
        step(1);
        chk("pulse_e10", bus.level_o, 0);
        chk("pulse_f10", bus.fall_o, 1);
        chk("pulse_cnt", bus.edge_cnt_o, 4);

        // 3: N=0 passthrough
        bus.debounce_cycles_i = 8'd0;
        step(4);
        n_rise = 0;
        n_fall = 0;
        n_both = 0;
        for (int i = 0; i < 24; i++) begin
            if (i < 20 && (i % 2) == 0) bus.rdata_i = ~bus.rdata_i;
            step(1);
            chk("n0_track", bus.level_o, hist[2]);
        end
        chk("n0_rises", n_rise, 5);
        chk("n0_falls", n_fall, 5);
        chk("n0_both",  n_both, 0);
        chk("n0_cnt",   bus.edge_cnt_o, 14);
        chk("n0_irq",   bus.irq_o, 0);

        // 4: interrupt on fall only
        bus.irq_en_i = 2'b10;
        bus.rdata_i  = 1'b1;
        step(3);
        chk("irq_rise_p", bus.rise_o, 1);
        chk("irq_rise",   bus.irq_o, 0);
        bus.rdata_i = 1'b0;
        step(3);
        chk("irq_fall_p", bus.fall_o, 1);
        chk("irq_fall",   bus.irq_o, 1);
        chk("cnt_wrap0",  bus.edge_cnt_o, 0);
        bus.rdata_i = 1'b1;
        step(4);
        bus.rdata_i = 1'b0;
        step(2);
        bus.irq_clr_i = 1'b1;
        step(1);
        chk("setclr_f",  bus.fall_o, 1);
        chk("setclr",    bus.irq_o, 1);
        step(1);
        chk("clr_only",  bus.irq_o, 0);
        bus.irq_clr_i = 1'b0;
        bus.irq_en_i  = 2'b00;

        // 5: counter clear and wrap
        bus.cnt_clr_i = 1'b1;
        step(1);
        bus.cnt_clr_i = 1'b0;
        chk("cnt_clr", bus.edge_cnt_o, 0);
        n_rise = 0;
        n_fall = 0;
        for (int i = 0; i < 36; i++) begin
            if (i < 32 && (i % 2) == 0) bus.rdata_i = ~bus.rdata_i;
            step(1);
        end
        chk("wrap_edges", n_rise + n_fall, 16);
        chk("wrap_cnt",   bus.edge_cnt_o, 0);
        bus.rdata_i = 1'b1;
        step(2);
        bus.cnt_clr_i = 1'b1;
        step(1);
        bus.cnt_clr_i = 1'b0;
        chk("clr_edge_r", bus.rise_o, 1);
        chk("clr_edge",   bus.edge_cnt_o, 1);

        // 6: reset in the middle of a window
        bus.rdata_i = 1'b0;
        step(5);
        chk("t6_lvl0", bus.level_o, 0);
        bus.debounce_cycles_i = 8'd10;
        bus.rdata_i = 1'b1;
        step(7);
        chk("t6_pre", bus.level_o, 0);
        rst_i = 1'b1;
        step(1);
        rst_i = 1'b0;
        chk("t6_rsync", bus.sync_o, 0);
        chk("t6_rlvl",  bus.level_o, 0);
        chk("t6_rcnt",  bus.edge_cnt_o, 0);
        step(12);
        chk("t6_e12", bus.level_o, 0);
        step(1);
        chk("t6_e13",  bus.level_o, 1);
        chk("t6_rise", bus.rise_o, 1);
        chk("t6_cnt",  bus.edge_cnt_o, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
